qcore_mem_ctrl: RTL and testbench

Single-clock memory subsystem for the qcore: program, data and wave memories with a parametrised geometry, plus a host-side burst engine. The engine executes read, write and optional fill bursts over valid/ready streams. The core keeps direct single-cycle ports on each memory. The host engine replaces word-at-a-time host access and sits between the AXI front-end and the core.

---
 rtl/qcore_mem_ctrl_if.sv | 30 +++
 rtl/qcore_mem_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_qcore_mem_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qcore_mem_ctrl_if.sv
// Host-side burst command and read/write stream bundle for qcore_mem_ctrl.
// The engine uses the slave modport; the host front-end drives the master side.
interface qcore_mem_ctrl_if;
    logic         ps_start_i;
    logic [1:0]   ps_sel_i;
    logic [1:0]   ps_mode_i;
    logic [15:0]  ps_addr_i;
    logic [15:0]  ps_len_i;
    logic         ps_busy_o;
    logic         ps_done_o;
    logic         ps_err_o;
    logic [167:0] ps_w_dt_i;
    logic         ps_w_vld_i;
    logic         ps_w_rdy_o;
    logic [167:0] ps_r_dt_o;
    logic         ps_r_vld_o;
    logic         ps_r_rdy_i;

    modport slave (
        input  ps_start_i, ps_sel_i, ps_mode_i, ps_addr_i, ps_len_i,
        input  ps_w_dt_i, ps_w_vld_i, ps_r_rdy_i,
        output ps_busy_o, ps_done_o, ps_err_o, ps_w_rdy_o, ps_r_dt_o, ps_r_vld_o
    );

    modport master (
        output ps_start_i, ps_sel_i, ps_mode_i, ps_addr_i, ps_len_i,
        output ps_w_dt_i, ps_w_vld_i, ps_r_rdy_i,
        input  ps_busy_o, ps_done_o, ps_err_o, ps_w_rdy_o, ps_r_dt_o, ps_r_vld_o
    );
endinterface

// File: rtl/qcore_mem_ctrl.sv
// qcore program/data/wave memories (core on port A, host burst engine on port B).
// Define QCORE_MEM_FILL_EN to build the FILL burst mode; otherwise mode 10 is rejected.
module qcore_mem_ctrl #(
    parameter int PMEM_AW = 8,
    parameter int DMEM_AW = 8,
    parameter int WMEM_AW = 8,
    parameter int PMEM_DW = 72,
    parameter int DMEM_DW = 32,
    parameter int WMEM_DW = 168
) (
    input  logic               c_clk_i,
    input  logic               c_rst_ni,
    qcore_mem_ctrl_if.slave    ps,
    input  logic               c_pmem_en_i,
    input  logic [PMEM_AW-1:0] c_pmem_addr_i,
    output logic [PMEM_DW-1:0] c_pmem_r_dt_o,
    input  logic               c_dmem_we_i,
    input  logic [DMEM_AW-1:0] c_dmem_addr_i,
    input  logic [DMEM_DW-1:0] c_dmem_w_dt_i,
    output logic [DMEM_DW-1:0] c_dmem_r_dt_o,
    input  logic               c_wmem_we_i,
    input  logic [WMEM_AW-1:0] c_wmem_addr_i,
    input  logic [WMEM_DW-1:0] c_wmem_w_dt_i,
    output logic [WMEM_DW-1:0] c_wmem_r_dt_o
);
    localparam int XW = 168;
    localparam logic [1:0] SEL_P  = 2'b01;
    localparam logic [1:0] SEL_D  = 2'b10;
    localparam logic [1:0] SEL_W  = 2'b11;
    localparam logic [1:0] M_WR   = 2'b01;
    localparam logic [1:0] M_FILL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_CHK, S_WR, S_RD,
`ifdef QCORE_MEM_FILL_EN
        S_FILL,
`endif
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    sel_q, mode_q;
    logic [15:0]   addr_q, rem_q, iss_q;
    logic          err_q;
`ifdef QCORE_MEM_FILL_EN
    logic [XW-1:0] fill_q;
`endif

    logic [XW-1:0] buf_q [2];
    logic          wp_q, rp_q;
    logic [1:0]    cnt_q;

    logic          bad, beat, rd_iss, pop, w_rdy, r_vld;
    logic [XW-1:0] hb_wdt, rd_word;
    logic [16:0]   end_a, lim;

    logic [PMEM_DW-1:0] pmem_q [2**PMEM_AW];
    logic [DMEM_DW-1:0] dmem_q [2**DMEM_AW];
    logic [WMEM_DW-1:0] wmem_q [2**WMEM_AW];
    logic [PMEM_DW-1:0] prd_q;
    logic [DMEM_DW-1:0] drd_q;
    logic [WMEM_DW-1:0] wrd_q;

    logic [PMEM_AW-1:0] pa;
    logic [DMEM_AW-1:0] da;
    logic [WMEM_AW-1:0] wa;

    assign pa    = addr_q[PMEM_AW-1:0];
    assign da    = addr_q[DMEM_AW-1:0];
    assign wa    = addr_q[WMEM_AW-1:0];
    assign r_vld = (cnt_q != 2'd0);
    assign pop   = r_vld && ps.ps_r_rdy_i;

    // Command legality, evaluated against the latched command while in CHK.
    always_comb begin
        lim = '0;
        case (sel_q)
            SEL_P:   lim = 17'(1) << PMEM_AW;
            SEL_D:   lim = 17'(1) << DMEM_AW;
            SEL_W:   lim = 17'(1) << WMEM_AW;
            default: lim = '0;
        endcase
        end_a = {1'b0, addr_q} + {1'b0, rem_q};
        bad   = (sel_q == 2'b00) || (mode_q == 2'b11) || (rem_q == '0) || (end_a > lim);
`ifndef QCORE_MEM_FILL_EN
        bad   = bad || (mode_q == M_FILL);
`endif
    end

    always_comb begin
        state_d = state_q;
        beat    = 1'b0;
        rd_iss  = 1'b0;
        w_rdy   = 1'b0;
        hb_wdt  = ps.ps_w_dt_i;
        case (state_q)
            S_IDLE: if (ps.ps_start_i) state_d = S_CHK;
            S_CHK: begin
                if (bad)                   state_d = S_DONE;
                else if (mode_q == M_WR)   state_d = S_WR;
`ifdef QCORE_MEM_FILL_EN
                else if (mode_q == M_FILL) state_d = S_FILL;
`endif
                else                       state_d = S_RD;
            end
            S_WR: begin
                w_rdy = 1'b1;
                beat  = ps.ps_w_vld_i;
                if (beat && rem_q == 16'd1) state_d = S_DONE;
            end
            S_RD: begin
                // A pop in the same cycle frees a slot, so a full buffer can still issue.
                rd_iss = (iss_q != '0) && ((cnt_q != 2'd2) || pop);
                if (pop && rem_q == 16'd1) state_d = S_DONE;
            end
`ifdef QCORE_MEM_FILL_EN
            S_FILL: begin
                beat   = 1'b1;
                hb_wdt = fill_q;
                if (rem_q == 16'd1) state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        rd_word = '0;
        case (sel_q)
            SEL_P:   rd_word[PMEM_DW-1:0] = pmem_q[pa];
            SEL_D:   rd_word[DMEM_DW-1:0] = dmem_q[da];
            SEL_W:   rd_word[WMEM_DW-1:0] = wmem_q[wa];
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            sel_q    <= '0;
            mode_q   <= '0;
            addr_q   <= '0;
            rem_q    <= '0;
            iss_q    <= '0;
            err_q    <= 1'b0;
`ifdef QCORE_MEM_FILL_EN
            fill_q   <= '0;
`endif
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (state_q == S_IDLE && ps.ps_start_i) begin
                sel_q  <= ps.ps_sel_i;
                mode_q <= ps.ps_mode_i;
                addr_q <= ps.ps_addr_i;
                rem_q  <= ps.ps_len_i;
                iss_q  <= ps.ps_len_i;
                err_q  <= 1'b0;
`ifdef QCORE_MEM_FILL_EN
                fill_q <= ps.ps_w_dt_i;
`endif
            end
            if (state_q == S_CHK && bad) err_q <= 1'b1;
            if (beat) begin
                addr_q <= addr_q + 16'd1;
                rem_q  <= rem_q - 16'd1;
            end
            if (rd_iss) begin
                addr_q       <= addr_q + 16'd1;
                iss_q        <= iss_q - 16'd1;
                buf_q[wp_q]  <= rd_word;
                wp_q         <= ~wp_q;
            end
            if (pop) begin
                rem_q <= rem_q - 16'd1;
                rp_q  <= ~rp_q;
            end
            cnt_q <= cnt_q + {1'b0, rd_iss} - {1'b0, pop};
        end
    end

    // Memory arrays carry no reset; a core write to the same word drops the host write.
    always_ff @(posedge c_clk_i) begin
        if (beat && sel_q == SEL_P) pmem_q[pa] <= hb_wdt[PMEM_DW-1:0];
    end

    always_ff @(posedge c_clk_i) begin
        if (c_dmem_we_i) dmem_q[c_dmem_addr_i] <= c_dmem_w_dt_i;
        if (beat && sel_q == SEL_D && !(c_dmem_we_i && c_dmem_addr_i == da))
            dmem_q[da] <= hb_wdt[DMEM_DW-1:0];
    end

    always_ff @(posedge c_clk_i) begin
        if (c_wmem_we_i) wmem_q[c_wmem_addr_i] <= c_wmem_w_dt_i;
        if (beat && sel_q == SEL_W && !(c_wmem_we_i && c_wmem_addr_i == wa))
            wmem_q[wa] <= hb_wdt[WMEM_DW-1:0];
    end

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            prd_q <= '0;
            drd_q <= '0;
            wrd_q <= '0;
        end else begin
            if (c_pmem_en_i) prd_q <= pmem_q[c_pmem_addr_i];
            drd_q <= dmem_q[c_dmem_addr_i];
            wrd_q <= wmem_q[c_wmem_addr_i];
        end
    end

    assign c_pmem_r_dt_o = prd_q;
    assign c_dmem_r_dt_o = drd_q;
    assign c_wmem_r_dt_o = wrd_q;

    assign ps.ps_busy_o  = (state_q != S_IDLE);
    assign ps.ps_done_o  = (state_q == S_DONE);
    assign ps.ps_err_o   = err_q;
    assign ps.ps_w_rdy_o = w_rdy;
    assign ps.ps_r_vld_o = r_vld;
    assign ps.ps_r_dt_o  = buf_q[rp_q];
endmodule

// File: tb/tb_qcore_mem_ctrl.sv
// Self-checking bench for qcore_mem_ctrl: vector table, directed corner sequences
// and randomized bursts against an array-based memory model.
module tb_qcore_mem_ctrl;
    localparam int PA = 8, DA = 8, WA = 8, PD = 72, DD = 32, WD = 168;
`ifdef QCORE_MEM_FILL_EN
    localparam bit FILL_ON = 1'b1;
`else
    localparam bit FILL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qcore_mem_ctrl_if ps_if ();

    logic          c_pmem_en;
    logic [PA-1:0] c_pmem_addr;
    logic [PD-1:0] c_pmem_r_dt;
    logic          c_dmem_we;
    logic [DA-1:0] c_dmem_addr;
    logic [DD-1:0] c_dmem_w_dt, c_dmem_r_dt;
    logic          c_wmem_we;
    logic [WA-1:0] c_wmem_addr;
    logic [WD-1:0] c_wmem_w_dt, c_wmem_r_dt;

    qcore_mem_ctrl #(
        .PMEM_AW(PA), .DMEM_AW(DA), .WMEM_AW(WA),
        .PMEM_DW(PD), .DMEM_DW(DD), .WMEM_DW(WD)
    ) dut (
        .c_clk_i       (clk),
        .c_rst_ni      (rst_n),
        .ps            (ps_if),
        .c_pmem_en_i   (c_pmem_en),
        .c_pmem_addr_i (c_pmem_addr),
        .c_pmem_r_dt_o (c_pmem_r_dt),
        .c_dmem_we_i   (c_dmem_we),
        .c_dmem_addr_i (c_dmem_addr),
        .c_dmem_w_dt_i (c_dmem_w_dt),
        .c_dmem_r_dt_o (c_dmem_r_dt),
        .c_wmem_we_i   (c_wmem_we),
        .c_wmem_addr_i (c_wmem_addr),
        .c_wmem_w_dt_i (c_wmem_w_dt),
        .c_wmem_r_dt_o (c_wmem_r_dt)
    );

    // Model: mdl[sel][addr] holds each memory word, masked to its width.
    logic [167:0] mdl  [4][256];
    logic [167:0] wbuf [256];
    logic [167:0] got  [$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [1:0]  mode;
        logic [15:0] addr;
        logic [15:0] len;
        int          wpat;
        int          rpat;
        bit          err;
    } vec_t;
    vec_t vt [9];

    task automatic chk(input string nm, input logic [167:0] act, input logic [167:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [167:0] rnd168();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[167:0];
    endfunction

    function automatic logic [167:0] msk(input logic [1:0] s);
        logic [167:0] m;
        m = '1;
        case (s)
            2'd1: m = m >> (168 - PD);
            2'd2: m = m >> (168 - DD);
            2'd3: m = m >> (168 - WD);
            default: m = '1;
        endcase
        return m;
    endfunction

    function automatic bit model_err(input logic [1:0] s, input logic [1:0] m,
                                     input logic [15:0] a, input logic [15:0] l);
        int aw;
        aw = (s == 2'd1) ? PA : (s == 2'd2) ? DA : WA;
        return (s == 2'd0) || (m == 2'd3) || (m == 2'd2 && !FILL_ON) || (l == 16'd0) ||
               (int'(a) + int'(l) > (1 << aw));
    endfunction

    // 0 always, 1 every other cycle, 2 repeating 1,0,0,1, else random
    function automatic bit pat(input int p, input int t);
        case (p)
            0: return 1'b1;
            1: return (t % 2) == 1;
            2: return ((t % 4) == 0) || ((t % 4) == 3);
            default: return $urandom_range(0, 1) == 1;
        endcase
    endfunction

    task automatic run_cmd(input logic [1:0] sel, input logic [1:0] mode, input logic [15:0] addr,
                           input logic [15:0] len, input logic [167:0] fill, input int wpat,
                           input int rpat, input bit exp_err, input string tag);
        int t, wi, t_done, t_wrdy, t_rvld, nstab, lim;
        bit hold, err_seen;
        logic [167:0] held;
        got.delete();
        t_done = -1; t_wrdy = -1; t_rvld = -1; wi = 0; nstab = 0;
        hold = 1'b0; err_seen = 1'b0; held = '0;
        lim = 4 * int'(len) + 40;
        ps_if.ps_start_i = 1'b1;
        ps_if.ps_sel_i   = sel;
        ps_if.ps_mode_i  = mode;
        ps_if.ps_addr_i  = addr;
        ps_if.ps_len_i   = len;
        ps_if.ps_w_dt_i  = fill;
        @(negedge clk);
        ps_if.ps_start_i = 1'b0;
        t = 1;
        chk({tag, " busy@T+1"}, 168'(ps_if.ps_busy_o), 168'(1));
        while (t_done < 0 && t < lim) begin
            if (ps_if.ps_done_o) begin
                t_done = t;
                err_seen = ps_if.ps_err_o;
            end
            if (ps_if.ps_w_rdy_o && t_wrdy < 0) t_wrdy = t;
            if (ps_if.ps_r_vld_o && t_rvld < 0) t_rvld = t;
            if (hold && ps_if.ps_r_dt_o !== held) nstab++;
            ps_if.ps_w_vld_i = (wi < int'(len)) && (wi < 256) && pat(wpat, t);
            ps_if.ps_w_dt_i  = (wi < 256) ? wbuf[wi] : '0;
            if (ps_if.ps_w_vld_i && ps_if.ps_w_rdy_o) wi++;
            ps_if.ps_r_rdy_i = pat(rpat, t);
            if (ps_if.ps_r_vld_o && ps_if.ps_r_rdy_i) got.push_back(ps_if.ps_r_dt_o);
            hold = ps_if.ps_r_vld_o && !ps_if.ps_r_rdy_i;
            held = ps_if.ps_r_dt_o;
            @(negedge clk);
            t++;
        end
        ps_if.ps_w_vld_i = 1'b0;
        ps_if.ps_r_rdy_i = 1'b0;
        if (t_done < 0) chk({tag, " done timeout"}, 168'(0), 168'(1));
        chk({tag, " done single pulse"}, 168'(ps_if.ps_done_o), 168'(0));
        chk({tag, " busy after done"}, 168'(ps_if.ps_busy_o), 168'(0));
        chk({tag, " err"}, 168'(err_seen), 168'(exp_err));
        if (exp_err) begin
            chk({tag, " reject done cycle"}, 168'(t_done), 168'(2));
        end else if (mode == 2'd1) begin
            chk({tag, " first w_rdy"}, 168'(t_wrdy), 168'(2));
            if (wpat == 0) chk({tag, " write done cycle"}, 168'(t_done), 168'(int'(len) + 2));
            for (int i = 0; i < int'(len); i++) mdl[sel][int'(addr) + i] = wbuf[i] & msk(sel);
        end else if (mode == 2'd0) begin
            chk({tag, " first r_vld"}, 168'(t_rvld), 168'(3));
            chk({tag, " read count"}, 168'(got.size()), 168'(len));
            for (int i = 0; i < int'(len) && i < got.size(); i++)
                chk({tag, " read data"}, got[i], mdl[sel][int'(addr) + i]);
            chk({tag, " stall stability"}, 168'(nstab), 168'(0));
            if (rpat == 0) chk({tag, " read done cycle"}, 168'(t_done), 168'(int'(len) + 3));
        end else begin
            chk({tag, " fill done cycle"}, 168'(t_done), 168'(int'(len) + 2));
            for (int i = 0; i < int'(len); i++) mdl[sel][int'(addr) + i] = fill & msk(sel);
        end
    endtask

    task automatic core_rd(input int sel, input int a, output logic [167:0] d);
        c_pmem_en   = 1'b1;
        c_pmem_addr = PA'(a);
        c_dmem_addr = DA'(a);
        c_wmem_addr = WA'(a);
        @(negedge clk);
        d = (sel == 1) ? 168'(c_pmem_r_dt) : (sel == 2) ? 168'(c_dmem_r_dt) : 168'(c_wmem_r_dt);
        c_pmem_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [167:0] d;
        logic [167:0] saved [4];
        logic [1:0] s, m;
        logic [15:0] a, l;
        int r;

        ps_if.ps_start_i = 1'b0; ps_if.ps_sel_i = '0; ps_if.ps_mode_i = '0;
        ps_if.ps_addr_i = '0; ps_if.ps_len_i = '0; ps_if.ps_w_dt_i = '0;
        ps_if.ps_w_vld_i = 1'b0; ps_if.ps_r_rdy_i = 1'b0;
        c_pmem_en = 1'b0; c_pmem_addr = '0;
        c_dmem_we = 1'b0; c_dmem_addr = '0; c_dmem_w_dt = '0;
        c_wmem_we = 1'b0; c_wmem_addr = '0; c_wmem_w_dt = '0;

        repeat (3) @(negedge clk);
        chk("rst busy",  168'(ps_if.ps_busy_o),  168'(0));
        chk("rst done",  168'(ps_if.ps_done_o),  168'(0));
        chk("rst err",   168'(ps_if.ps_err_o),   168'(0));
        chk("rst w_rdy", 168'(ps_if.ps_w_rdy_o), 168'(0));
        chk("rst r_vld", 168'(ps_if.ps_r_vld_o), 168'(0));
        chk("rst r_dt",  ps_if.ps_r_dt_o,        168'(0));
        chk("rst p_rd",  168'(c_pmem_r_dt),      168'(0));
        chk("rst d_rd",  168'(c_dmem_r_dt),      168'(0));
        chk("rst w_rd",  168'(c_wmem_r_dt),      168'(0));
        #2 rst_n = 1'b1;
        @(negedge clk);

        for (int sl = 1; sl < 4; sl++) begin
            for (int i = 0; i < 256; i++) wbuf[i] = rnd168();
            run_cmd(2'(sl), 2'd1, 16'd0, 16'd256, '0, 0, 0, 1'b0, "init");
        end

        // Gapped write then back-to-back read
        wbuf[0] = 168'hA; wbuf[1] = 168'hB; wbuf[2] = 168'hC;
        run_cmd(2'd2, 2'd1, 16'd4, 16'd3, '0, 1, 0, 1'b0, "wrD4");
        run_cmd(2'd2, 2'd0, 16'd4, 16'd3, '0, 0, 0, 1'b0, "rdD4");
        if (got.size() == 3) begin
            chk("rdD4 w0", got[0], 168'hA);
            chk("rdD4 w1", got[1], 168'hB);
            chk("rdD4 w2", got[2], 168'hC);
        end

        run_cmd(2'd3, 2'd0, 16'd0, 16'd8, '0, 0, 2, 1'b0, "rdW_stall");

        vt[0] = '{2'd0, 2'd0, 16'd0,   16'd1,  0, 0, 1'b1};
        vt[1] = '{2'd1, 2'd1, 16'd250, 16'd10, 0, 0, 1'b1};
        vt[2] = '{2'd2, 2'd0, 16'd4,   16'd0,  0, 0, 1'b1};
        vt[3] = '{2'd2, 2'd3, 16'd0,   16'd1,  0, 0, 1'b1};
        vt[4] = '{2'd2, 2'd1, 16'd255, 16'd1,  0, 0, 1'b0};
        vt[5] = '{2'd2, 2'd0, 16'd255, 16'd2,  0, 0, 1'b1};
        vt[6] = '{2'd3, 2'd0, 16'd248, 16'd8,  0, 0, 1'b0};
        vt[7] = '{2'd2, 2'd2, 16'd32,  16'd2,  0, 0, !FILL_ON};
        vt[8] = '{2'd1, 2'd0, 16'd0,   16'd4,  0, 3, 1'b0};
        for (int i = 0; i < 9; i++)
            run_cmd(vt[i].sel, vt[i].mode, vt[i].addr, vt[i].len, rnd168(),
                    vt[i].wpat, vt[i].rpat, vt[i].err, $sformatf("vec%0d", i));
        core_rd(1, 250, d);
        chk("P[250] after reject", d, mdl[1][250]);

        for (int i = 0; i < 4; i++) saved[i] = mdl[3][16 + i];
        run_cmd(2'd3, 2'd2, 16'd16, 16'd4, 168'h55, 0, 0, !FILL_ON, "fillW");
        for (int i = 0; i < 4; i++) begin
            core_rd(3, 16 + i, d);
            chk("fillW word", d, FILL_ON ? 168'h55 : saved[i]);
        end

        // Host and core write D[7] in the same cycle
        ps_if.ps_start_i = 1'b1; ps_if.ps_sel_i = 2'd2; ps_if.ps_mode_i = 2'd1;
        ps_if.ps_addr_i = 16'd7; ps_if.ps_len_i = 16'd1;
        ps_if.ps_w_dt_i = 168'h1; ps_if.ps_w_vld_i = 1'b1;
        @(negedge clk);
        ps_if.ps_start_i = 1'b0;
        @(negedge clk);
        chk("coll w_rdy", 168'(ps_if.ps_w_rdy_o), 168'(1));
        c_dmem_we = 1'b1; c_dmem_addr = 8'd7; c_dmem_w_dt = 32'h2;
        @(negedge clk);
        c_dmem_we = 1'b0; ps_if.ps_w_vld_i = 1'b0;
        chk("coll done", 168'(ps_if.ps_done_o), 168'(1));
        chk("coll err",  168'(ps_if.ps_err_o),  168'(0));
        mdl[2][7] = 168'h2;
        @(negedge clk);
        core_rd(2, 7, d);
        chk("coll D[7]", d, 168'h2);

        // Reset while a read burst is stalled with a full buffer
        ps_if.ps_start_i = 1'b1; ps_if.ps_sel_i = 2'd3; ps_if.ps_mode_i = 2'd0;
        ps_if.ps_addr_i = 16'd0; ps_if.ps_len_i = 16'd8; ps_if.ps_r_rdy_i = 1'b0;
        @(negedge clk);
        ps_if.ps_start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-rst r_vld", 168'(ps_if.ps_r_vld_o), 168'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst busy",  168'(ps_if.ps_busy_o),  168'(0));
        chk("mid-rst r_vld", 168'(ps_if.ps_r_vld_o), 168'(0));
        chk("mid-rst done",  168'(ps_if.ps_done_o),  168'(0));
        chk("mid-rst w_rdy", 168'(ps_if.ps_w_rdy_o), 168'(0));
        chk("mid-rst r_dt",  ps_if.ps_r_dt_o,        168'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_cmd(2'd2, 2'd0, 16'd4, 16'd3, '0, 0, 0, 1'b0, "rd_after_rst");
        if (got.size() == 3) chk("rd_after_rst w0", got[0], 168'hA);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 7);
            s = (r == 0) ? 2'd0 : 2'(1 + r % 3);
            r = $urandom_range(0, 9);
            m = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
            a = 16'($urandom_range(0, 260));
            l = 16'($urandom_range(0, 10));
            for (int i = 0; i < 16; i++) wbuf[i] = rnd168();
            run_cmd(s, m, a, l, rnd168(), $urandom_range(0, 3), $urandom_range(0, 3),
                    model_err(s, m, a, l), $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
